split_sampler: RTL and testbench

Candidate generator and driver for one split constraint checker. On each request it drives pseudo-random `WIDTH`-bit assignments onto the checker's input and samples the checker's single satisfaction bit. It returns the first satisfying assignment, or a failure after `MAX_TRIES` candidates. It sits on the solver's stimulus side: it is the producer feeding the `x` of a `split_N` checker.

---
 rtl/split_sampler_pkg.sv | 23 ++
 rtl/split_sampler_if.sv | 33 +++
 rtl/split_sampler_lfsr.sv | 38 +++
 rtl/split_sampler.sv | 99 +++++++++
 tb/tb_split_sampler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/split_sampler_pkg.sv
// split_sampler shared types and helpers.
// State encoding, default LFSR constants and the Galois step function.
package split_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    HOLD  = 2'd2
  } split_state_t;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS_DEF = 16'hB400;
  localparam int LFSR_MAXW = 64;

  // Wide enough for any WIDTH; callers zero-extend and truncate.
  function automatic logic [LFSR_MAXW-1:0] lfsr_next(
    input logic [LFSR_MAXW-1:0] s,
    input logic [LFSR_MAXW-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/split_sampler_if.sv
// split_sampler request / checker / result bundle.
// master = requester and checker side, slave = sampler.
interface split_sampler_if #(
  parameter int WIDTH     = 16,
  parameter int MAX_TRIES = 64,
  parameter int TW        = $clog2(MAX_TRIES + 1)
);
  logic             req_valid;
  logic             req_ready;
  logic             seed_load;
  logic [WIDTH-1:0] seed_value;
  logic [WIDTH-1:0] cand;
  logic             chk_x;
  logic             sol_valid;
  logic             sol_ready;
  logic [WIDTH-1:0] sol_data;
  logic [TW-1:0]    sol_tries;
  logic             sol_fail;

  modport master (
    output req_valid, seed_load, seed_value,
    output chk_x, sol_ready,
    input  req_ready, cand, sol_valid,
    input  sol_data, sol_tries, sol_fail
  );

  modport slave (
    input  req_valid, seed_load, seed_value,
    input  chk_x, sol_ready,
    output req_ready, cand, sol_valid,
    output sol_data, sol_tries, sol_fail
  );
endinterface

// File: rtl/split_sampler_lfsr.sv
// Candidate LFSR for split_sampler.
// Seed load with zero substitution, advance enable, else frozen.
module split_lfsr
  import split_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // A zero state would lock the LFSR, so it is never loaded.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = (seed_i == '0) ? SEED : seed_i;
    end else if (adv_i) begin
      q_d = WIDTH'(lfsr_next(LFSR_MAXW'(q_q),
                             LFSR_MAXW'(TAPS)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/split_sampler.sv
// split_sampler: drives LFSR candidates into a split checker
// and returns the first satisfying one or a fail after MAX_TRIES.
module split_sampler
  import split_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_DEF),
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_DEF),
  parameter int               MAX_TRIES = 64,
  parameter int               TW        = $clog2(MAX_TRIES + 1)
) (
  input logic            clk,
  input logic            rst_n,
  split_sampler_if.slave bus
);

  split_state_t     state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d, tries_inc;
  logic [TW-1:0]    stries_q, stries_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fail_q, fail_d;
  logic             is_idle, is_probe, is_hold;

  assign is_idle   = (state_q == IDLE);
  assign is_probe  = (state_q == PROBE);
  assign is_hold   = (state_q == HOLD);
  assign tries_inc = tries_q + 1'b1;

  split_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (is_idle & bus.seed_load),
    .seed_i (bus.seed_value),
    .adv_i  (is_probe),
    .q_o    (bus.cand)
  );

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    stries_d = stries_q;
    data_d   = data_q;
    fail_d   = fail_q;
    unique case (1'b1)
      is_idle: begin
        if (bus.req_valid) begin
          state_d = PROBE;
          tries_d = '0;
        end
      end
      is_probe: begin
        tries_d = tries_inc;
        // A hit on the last try still wins over the fail path.
        if (bus.chk_x) begin
          state_d  = HOLD;
          data_d   = bus.cand;
          stries_d = tries_inc;
          fail_d   = 1'b0;
        end else if (tries_inc == TW'(MAX_TRIES)) begin
          state_d  = HOLD;
          data_d   = '0;
          stries_d = TW'(MAX_TRIES);
          fail_d   = 1'b1;
        end
      end
      is_hold: begin
        if (bus.sol_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tries_q  <= '0;
      stries_q <= '0;
      data_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      stries_q <= stries_d;
      data_q   <= data_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.req_ready = is_idle;
  assign bus.sol_valid = is_hold;
  assign bus.sol_data  = data_q;
  assign bus.sol_tries = stries_q;
  assign bus.sol_fail  = fail_q;

endmodule

// File: tb/tb_split_sampler.sv
// Bench for split_sampler: transaction model plus per-cycle compare.
// Checker under test is chk_x = |cand[2:0] unless forced low.
module tb_split_sampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   force0 = 1'b0;
  bit   chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  split_sampler_if #(.WIDTH(16), .MAX_TRIES(64)) bus ();

  assign bus.chk_x = force0 ? 1'b0 : |bus.cand[2:0];

  split_sampler #(.WIDTH(16), .MAX_TRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] m_idle;
  logic [15:0] seq [64];
  int          e_tries;
  logic [15:0] e_data;
  logic        e_fail;
  int          pc;

  logic [15:0] got_data;
  int          got_tries;
  logic        got_fail;
  int          got_lat;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mnext(input logic [15:0] s);
    return (s / 2) ^ ((s % 2 != 0) ? 16'hB400 : 16'h0000);
  endfunction

  function automatic bit msat(input logic [15:0] c);
    return !force0 && (c % 8 != 0);
  endfunction

  // Whole request outcome from the current idle LFSR value.
  task automatic predict();
    logic [15:0] s;
    bit found;
    s = m_idle;
    found = 0;
    e_fail = 1'b1;
    e_data = 16'h0;
    e_tries = 64;
    for (int k = 0; k < 64 && !found; k++) begin
      seq[k] = s;
      found = msat(s);
      s = mnext(s);
      if (found) begin
        e_data = seq[k];
        e_tries = k + 1;
        e_fail = 1'b0;
      end
    end
    m_idle = s;
  endtask

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      if (bus.sol_valid) begin
        chk("hold_req_ready", bus.req_ready, 0);
        chk("sol_data", bus.sol_data, e_data);
        chk("sol_tries", bus.sol_tries, e_tries);
        chk("sol_fail", bus.sol_fail, e_fail);
        chk("hold_cand", bus.cand, m_idle);
      end else if (bus.req_ready) begin
        pc = 0;
        chk("idle_cand", bus.cand, m_idle);
      end else begin
        if (pc < 64) chk("probe_cand", bus.cand, seq[pc]);
        else         chk("probe_overrun", pc, 63);
        pc++;
      end
    end
  end

  task automatic start_req(input bit sl, input logic [15:0] sv);
    bus.req_valid = 1'b1;
    bus.seed_load = sl;
    bus.seed_value = sv;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.seed_load = 1'b0;
    if (sl) m_idle = (sv == 16'h0) ? 16'hACE1 : sv;
    predict();
  endtask

  task automatic finish_req(input int pre, input int hold_n);
    got_lat = pre;
    while (!bus.sol_valid && got_lat < 100) begin
      @(posedge clk); #1;
      got_lat++;
    end
    chk("latency", got_lat, e_tries);
    got_data = bus.sol_data;
    got_tries = int'(bus.sol_tries);
    got_fail = bus.sol_fail;
    if (bus.sol_valid) begin
      repeat (hold_n) @(posedge clk);
      #1;
      chk("hold_stable", bus.sol_data, got_data);
      bus.sol_ready = 1'b1;
      @(posedge clk); #1;
      bus.sol_ready = 1'b0;
      chk("rel_req_ready", bus.req_ready, 1);
      chk("rel_sol_valid", bus.sol_valid, 0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_value = 16'h0;
    bus.sol_ready = 1'b0;
    m_idle = 16'hACE1;
    pc = 0;
    #12;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_sol_valid", bus.sol_valid, 0);
    chk("rst_cand", bus.cand, 16'hACE1);
    chk("rst_sol_data", bus.sol_data, 0);
    chk("rst_sol_tries", bus.sol_tries, 0);
    chk("rst_sol_fail", bus.sol_fail, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;

    start_req(0, 16'h0);
    finish_req(0, 0);
    chk("r1_data", got_data, 16'hACE1);
    chk("r1_tries", got_tries, 1);
    chk("r1_fail", got_fail, 0);

    start_req(0, 16'h0);
    finish_req(0, 10);
    chk("r2_data", got_data, 16'h389C);
    chk("r2_tries", got_tries, 3);
    chk("r2_fail", got_fail, 0);

    bus.seed_load = 1'b1;
    bus.seed_value = 16'h0;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    m_idle = 16'hACE1;
    chk("seed0_cand", bus.cand, 16'hACE1);
    start_req(0, 16'h0);
    chk("seed0_first", bus.cand, 16'hACE1);
    finish_req(0, 0);

    force0 = 1'b1;
    start_req(0, 16'h0);
    repeat (5) @(posedge clk);
    #1;
    bus.seed_load = 1'b1;
    bus.seed_value = 16'h1234;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    finish_req(6, 3);
    chk("fail_lat", got_lat, 64);
    chk("fail_flag", got_fail, 1);
    chk("fail_data", got_data, 0);
    chk("fail_tries", got_tries, 64);
    force0 = 1'b0;

    start_req(1, 16'h0005);
    finish_req(0, 0);
    chk("seedreq_data", got_data, 16'h0005);
    chk("seedreq_tries", got_tries, 1);

    force0 = 1'b1;
    start_req(0, 16'h0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 1);
    chk("arst_sol_valid", bus.sol_valid, 0);
    chk("arst_cand", bus.cand, 16'hACE1);
    chk("arst_sol_data", bus.sol_data, 0);
    chk("arst_sol_tries", bus.sol_tries, 0);
    chk("arst_sol_fail", bus.sol_fail, 0);
    m_idle = 16'hACE1;
    force0 = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_req(0, 16'h0);
    finish_req(0, 0);
    chk("post_rst_data", got_data, 16'hACE1);
    chk("post_rst_tries", got_tries, 1);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
